mem_resp_stage: RTL and testbench

Parametrised memory-access pipeline stage for the five-stage LoongArch core, sitting between EX and WB. Unlike the fixed single-cycle MEM stage, it waits on a data-bus response handshake (`data_sram_data_ok`), buffers read data when WB stalls, and discards responses orphaned by an exception flush. It generalises load alignment and extension to `DATA_W`-bit buses with byte, half, word and (64-bit only) double loads.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_resp_stage_load_align.sv | 53 +++++
 rtl/mem_resp_stage.sv | 155 +++++++++++++++
 tb/tb_mem_resp_stage.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-response stage.
// Load-size codes, FSM states and the default exception-flag index.
package mem_pkg;

    localparam logic [1:0] LD_B = 2'd0;
    localparam logic [1:0] LD_H = 2'd1;
    localparam logic [1:0] LD_W = 2'd2;
    localparam logic [1:0] LD_D = 2'd3;

    localparam int EXC_BIT_DEF = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2,
        S_DROP = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_resp_stage_load_align.sv
// Load data alignment: shifts the addressed lane down and then
// sign- or zero-extends it to the full bus width.
module load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF_W-1:0]  addr,
    input  logic [1:0]        size,
    input  logic              unsgn,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] mask;
    logic              sbit;

    assign sh = rdata >> {addr, 3'b000};

    // A 32-bit word mask is all ones on a 32-bit bus, so size 3 and
    // word loads collapse to the same unextended result there.
    always_comb begin
        mask = '1;
        sbit = 1'b0;
        unique case (size)
            LD_B: begin
                mask = DATA_W'(8'hff);
                sbit = sh[7];
            end
            LD_H: begin
                mask = DATA_W'(16'hffff);
                sbit = sh[15];
            end
            LD_W: begin
                mask = DATA_W'(32'hffff_ffff);
                sbit = sh[31];
            end
            LD_D: begin
                mask = '1;
                sbit = 1'b0;
            end
            default: begin
                mask = '1;
                sbit = 1'b0;
            end
        endcase
    end

    assign data = (sh & mask) | ({DATA_W{sbit & ~unsgn}} & ~mask);

endmodule

// File: rtl/mem_resp_stage.sv
// MEM stage that waits on the data-bus response, buffers read data
// while WB stalls and discards responses orphaned by a flush.
module mem_resp_stage
    import mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int EXC_W   = 82,
    parameter int EXC_BIT = EXC_BIT_DEF,
    parameter int RA_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              EX_MEM_valid,
    output logic              MEM_allowin,
    input  logic [31:0]       EX_pc,
    input  logic [DATA_W-1:0] EX_alu_result,
    input  logic              EX_res_from_mem,
    input  logic              EX_mem_req,
    input  logic              EX_rf_we,
    input  logic [RA_W-1:0]   EX_rf_waddr,
    input  logic              EX_csr_re,
    input  logic [1:0]        EX_ld_size,
    input  logic              EX_ld_unsigned,
    input  logic [EXC_W-1:0]  EX_except_bus,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    input  logic              WB_allowin,
    input  logic              WB_EXC_signal,
    output logic              MEM_WB_valid,
    output logic [31:0]       MEM_pc,
    output logic              MEM_rf_we,
    output logic              MEM_csr_re,
    output logic [RA_W-1:0]   MEM_rf_waddr,
    output logic [DATA_W-1:0] MEM_rf_wdata,
    output logic [EXC_W-1:0]  MEM_except_bus,
    output logic              MEM_EXC_signal,
    output logic              MEM_ld_pending
);

    localparam int OFF_W = $clog2(DATA_W/8);

    mem_state_e state, state_nxt;

    logic [31:0]       pc_q;
    logic [DATA_W-1:0] alu_q;
    logic              res_q;
    logic              we_q;
    logic [RA_W-1:0]   waddr_q;
    logic              csr_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [EXC_W-1:0]  exc_q;
    logic [DATA_W-1:0] rbuf;

    logic              ready_go;
    logic              accept;
    logic              mem_valid;
    logic              rbuf_en;
    mem_state_e        acc_state;
    logic [DATA_W-1:0] ld_src;
    logic [DATA_W-1:0] ld_data;

    assign ready_go  = (state == S_FULL)
                     | ((state == S_WAIT) & data_sram_data_ok);
    assign MEM_allowin = reset | (state == S_IDLE)
                       | (ready_go & WB_allowin);
    assign accept    = EX_MEM_valid & MEM_allowin & ~WB_EXC_signal;
    assign acc_state = EX_mem_req ? S_WAIT : S_FULL;
    assign mem_valid = (state == S_WAIT) | (state == S_FULL);

    always_comb begin
        state_nxt = state;
        rbuf_en   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) state_nxt = acc_state;
            end
            S_WAIT: begin
                if (WB_EXC_signal) begin
                    state_nxt = data_sram_data_ok ? S_IDLE : S_DROP;
                end else if (data_sram_data_ok) begin
                    if (WB_allowin) begin
                        state_nxt = accept ? acc_state : S_IDLE;
                    end else begin
                        state_nxt = S_FULL;
                        rbuf_en   = 1'b1;
                    end
                end
            end
            S_FULL: begin
                if (WB_EXC_signal) begin
                    state_nxt = S_IDLE;
                end else if (WB_allowin) begin
                    state_nxt = accept ? acc_state : S_IDLE;
                end
            end
            S_DROP: begin
                if (data_sram_data_ok) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            pc_q    <= '0;
            alu_q   <= '0;
            res_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            csr_q   <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            exc_q   <= '0;
            rbuf    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                pc_q    <= EX_pc;
                alu_q   <= EX_alu_result;
                res_q   <= EX_res_from_mem;
                we_q    <= EX_rf_we;
                waddr_q <= EX_rf_waddr;
                csr_q   <= EX_csr_re;
                size_q  <= EX_ld_size;
                uns_q   <= EX_ld_unsigned;
                exc_q   <= EX_except_bus;
            end
            if (rbuf_en) rbuf <= data_sram_rdata;
        end
    end

    // Live bus data while waiting, buffered data once parked in FULL.
    assign ld_src = (state == S_WAIT) ? data_sram_rdata : rbuf;

    load_align #(.DATA_W(DATA_W)) u_align (
        .rdata (ld_src),
        .addr  (alu_q[OFF_W-1:0]),
        .size  (size_q),
        .unsgn (uns_q),
        .data  (ld_data)
    );

    assign MEM_WB_valid   = ready_go & ~reset;
    assign MEM_pc         = pc_q;
    assign MEM_rf_we      = we_q & mem_valid & ~reset;
    assign MEM_csr_re     = csr_q & mem_valid & ~reset;
    assign MEM_rf_waddr   = waddr_q;
    assign MEM_rf_wdata   = reset ? '0 : (res_q ? ld_data : alu_q);
    assign MEM_except_bus = reset ? '0 : exc_q;
    assign MEM_EXC_signal = mem_valid & exc_q[EXC_BIT] & ~reset;
    assign MEM_ld_pending = (state == S_WAIT) & res_q & ~reset;

endmodule

// File: tb/tb_mem_resp_stage.sv
// Directed bench for mem_resp_stage: 32-bit instance for the main
// scenarios plus a 64-bit instance for double loads and reset.
module tb_mem_resp_stage;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ex_valid, v64;
    logic [31:0] ex_pc;
    logic [31:0] ex_alu;
    logic [63:0] alu64;
    logic        ex_res, ex_req, ex_we, ex_csr, ex_uns;
    logic [4:0]  ex_waddr;
    logic [1:0]  ex_size;
    logic [81:0] ex_exc;
    logic        dok, dok64;
    logic [31:0] rdata;
    logic [63:0] rdata64;
    logic        wb_allow, wb_exc;

    logic        o_allow, o_valid, o_we, o_csr, o_excs, o_pend;
    logic [31:0] o_pc, o_wdata;
    logic [4:0]  o_waddr;
    logic [81:0] o_exc;

    logic        p_allow, p_valid, p_we, p_csr, p_excs, p_pend;
    logic [31:0] p_pc;
    logic [63:0] p_wdata;
    logic [4:0]  p_waddr;
    logic [81:0] p_exc;

    int errors = 0;
    int checks = 0;

    mem_resp_stage #(.DATA_W(32)) u32 (
        .clk(clk), .reset(reset),
        .EX_MEM_valid(ex_valid), .MEM_allowin(o_allow),
        .EX_pc(ex_pc), .EX_alu_result(ex_alu),
        .EX_res_from_mem(ex_res), .EX_mem_req(ex_req),
        .EX_rf_we(ex_we), .EX_rf_waddr(ex_waddr),
        .EX_csr_re(ex_csr), .EX_ld_size(ex_size),
        .EX_ld_unsigned(ex_uns), .EX_except_bus(ex_exc),
        .data_sram_data_ok(dok), .data_sram_rdata(rdata),
        .WB_allowin(wb_allow), .WB_EXC_signal(wb_exc),
        .MEM_WB_valid(o_valid), .MEM_pc(o_pc),
        .MEM_rf_we(o_we), .MEM_csr_re(o_csr),
        .MEM_rf_waddr(o_waddr), .MEM_rf_wdata(o_wdata),
        .MEM_except_bus(o_exc), .MEM_EXC_signal(o_excs),
        .MEM_ld_pending(o_pend)
    );

    mem_resp_stage #(.DATA_W(64)) u64 (
        .clk(clk), .reset(reset),
        .EX_MEM_valid(v64), .MEM_allowin(p_allow),
        .EX_pc(ex_pc), .EX_alu_result(alu64),
        .EX_res_from_mem(ex_res), .EX_mem_req(ex_req),
        .EX_rf_we(ex_we), .EX_rf_waddr(ex_waddr),
        .EX_csr_re(ex_csr), .EX_ld_size(ex_size),
        .EX_ld_unsigned(ex_uns), .EX_except_bus(ex_exc),
        .data_sram_data_ok(dok64), .data_sram_rdata(rdata64),
        .WB_allowin(wb_allow), .WB_EXC_signal(wb_exc),
        .MEM_WB_valid(p_valid), .MEM_pc(p_pc),
        .MEM_rf_we(p_we), .MEM_csr_re(p_csr),
        .MEM_rf_waddr(p_waddr), .MEM_rf_wdata(p_wdata),
        .MEM_except_bus(p_exc), .MEM_EXC_signal(p_excs),
        .MEM_ld_pending(p_pend)
    );

    // The bench must never send a response the stage does not owe.
    always @(negedge clk) begin
        if (!reset && dok &&
            (u32.state == S_IDLE || u32.state == S_FULL)) begin
            errors++;
            $display("FAIL proto32: data_ok in state %0d", u32.state);
        end
        if (!reset && dok64 &&
            (u64.state == S_IDLE || u64.state == S_FULL)) begin
            errors++;
            $display("FAIL proto64: data_ok in state %0d", u64.state);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        ex_valid = 0; v64 = 0; ex_pc = 0; ex_alu = 0; alu64 = 0;
        ex_res = 0; ex_req = 0; ex_we = 0; ex_csr = 0; ex_uns = 0;
        ex_waddr = 0; ex_size = 0; ex_exc = 0;
        dok = 0; dok64 = 0; rdata = 0; rdata64 = 0;
        wb_allow = 1; wb_exc = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        ex_valid = 1; ex_alu = 32'h99; ex_we = 1;
        cyc();
        #3;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", o_valid); end
        checks++; if (o_allow !== 1'b1) begin errors++; $display("FAIL rst_allowin got %b want 1", o_allow); end
        checks++; if (o_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", o_wdata); end
        checks++; if ({o_we, o_csr, o_excs, o_pend} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b want 0000", {o_we, o_csr, o_excs, o_pend}); end
        checks++; if (o_exc !== 82'h0) begin errors++; $display("FAIL rst_exc got %h want 0", o_exc); end
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", o_pc); end
        quiet();
        reset = 0;
        cyc();
        checks++; if (u32.state !== S_IDLE) begin errors++; $display("FAIL rst_state got %0d want IDLE", u32.state); end
    endtask

    task automatic test_alu();
        ex_valid = 1; ex_pc = 32'h100; ex_alu = 32'h1234;
        ex_we = 1; ex_waddr = 5'd5; ex_csr = 1;
        #3;
        checks++; if (o_allow !== 1'b1) begin errors++; $display("FAIL alu_allowin got %b want 1", o_allow); end
        cyc();
        quiet();
        #3;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL alu_valid got %b want 1", o_valid); end
        checks++; if (o_wdata !== 32'h1234) begin errors++; $display("FAIL alu_wdata got %h want 1234", o_wdata); end
        checks++; if ({o_we, o_csr, o_waddr} !== {2'b11, 5'd5}) begin errors++; $display("FAIL alu_ctrl got %b want 1100101", {o_we, o_csr, o_waddr}); end
        checks++; if (o_pc !== 32'h100) begin errors++; $display("FAIL alu_pc got %h want 100", o_pc); end
        cyc();
        checks++; if (u32.state !== S_IDLE) begin errors++; $display("FAIL alu_idle got %0d want IDLE", u32.state); end
    endtask

    task automatic test_exc();
        ex_valid = 1; ex_alu = 32'h8;
        ex_exc = 82'h2_0000_0000_0000_0000_0004;
        cyc();
        quiet();
        #3;
        checks++; if (o_excs !== 1'b1) begin errors++; $display("FAIL exc_sig got %b want 1", o_excs); end
        checks++; if (o_exc !== 82'h2_0000_0000_0000_0000_0004) begin errors++; $display("FAIL exc_bus got %h", o_exc); end
        cyc();
    endtask

    task automatic test_ld_b();
        ex_valid = 1; ex_alu = 32'h1003; ex_res = 1; ex_req = 1;
        ex_we = 1; ex_size = LD_B; ex_uns = 0;
        cyc();
        quiet();
        #3;
        checks++; if (o_pend !== 1'b1) begin errors++; $display("FAIL ldb_pend1 got %b want 1", o_pend); end
        checks++; if ({o_valid, o_allow} !== 2'b00) begin errors++; $display("FAIL ldb_wait got %b want 00", {o_valid, o_allow}); end
        cyc();
        #3;
        checks++; if (o_pend !== 1'b1) begin errors++; $display("FAIL ldb_pend2 got %b want 1", o_pend); end
        cyc();
        dok = 1; rdata = 32'h80ff_0000;
        #3;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL ldb_valid got %b want 1", o_valid); end
        checks++; if (o_wdata !== 32'hffff_ff80) begin errors++; $display("FAIL ldb_wdata got %h want ffffff80", o_wdata); end
        cyc();
        quiet();
        #3;
        checks++; if ({u32.state == S_IDLE, o_pend} !== 2'b10) begin errors++; $display("FAIL ldb_after got %0d/%b want IDLE/0", u32.state, o_pend); end
    endtask

    task automatic test_wb_stall();
        ex_valid = 1; ex_alu = 32'h2002; ex_res = 1; ex_req = 1;
        ex_we = 1; ex_size = LD_H; ex_uns = 1;
        cyc();
        quiet();
        dok = 1; rdata = 32'hbeef_1234; wb_allow = 0;
        #3;
        checks++; if (o_allow !== 1'b0) begin errors++; $display("FAIL stall_allow got %b want 0", o_allow); end
        cyc();
        dok = 0; rdata = 32'hdead_dead; wb_allow = 0;
        #3;
        checks++; if (u32.state !== S_FULL) begin errors++; $display("FAIL stall_full got %0d want FULL", u32.state); end
        checks++; if ({o_valid, o_pend} !== 2'b10) begin errors++; $display("FAIL stall_flags got %b want 10", {o_valid, o_pend}); end
        cyc();
        cyc();
        cyc();
        wb_allow = 1;
        #3;
        checks++; if (o_wdata !== 32'h0000_beef) begin errors++; $display("FAIL stall_wdata got %h want 0000beef", o_wdata); end
        checks++; if (o_allow !== 1'b1) begin errors++; $display("FAIL stall_allow2 got %b want 1", o_allow); end
        cyc();
        checks++; if (u32.state !== S_IDLE) begin errors++; $display("FAIL stall_idle got %0d want IDLE", u32.state); end
    endtask

    task automatic test_flush_wait();
        ex_valid = 1; ex_alu = 32'h3000; ex_res = 1; ex_req = 1;
        ex_we = 1; ex_size = LD_W;
        cyc();
        quiet();
        wb_exc = 1;
        #3;
        checks++; if ({o_allow, o_valid} !== 2'b00) begin errors++; $display("FAIL fl_c0 got %b want 00", {o_allow, o_valid}); end
        cyc();
        wb_exc = 0;
        ex_valid = 1; ex_alu = 32'h55; ex_we = 1;
        for (int i = 0; i < 2; i++) begin
            #3;
            checks++; if ({o_allow, o_valid, u32.state == S_DROP} !== 3'b001) begin errors++; $display("FAIL fl_drop%0d got %b want 001", i, {o_allow, o_valid, u32.state == S_DROP}); end
            cyc();
        end
        dok = 1; rdata = 32'hffff_ffff;
        #3;
        checks++; if ({o_allow, o_valid} !== 2'b00) begin errors++; $display("FAIL fl_dok got %b want 00", {o_allow, o_valid}); end
        cyc();
        dok = 0;
        #3;
        checks++; if ({u32.state == S_IDLE, o_allow} !== 2'b11) begin errors++; $display("FAIL fl_idle got %0d/%b want IDLE/1", u32.state, o_allow); end
        cyc();
        quiet();
        #3;
        checks++; if ({o_valid, o_wdata} !== {1'b1, 32'h55}) begin errors++; $display("FAIL fl_new got %b/%h want 1/55", o_valid, o_wdata); end
        cyc();
    endtask

    task automatic test_flush_same();
        ex_valid = 1; ex_alu = 32'h4000; ex_res = 1; ex_req = 1;
        cyc();
        quiet();
        wb_exc = 1; dok = 1; rdata = 32'h1;
        cyc();
        quiet();
        #3;
        checks++; if (u32.state !== S_IDLE) begin errors++; $display("FAIL fs_idle got %0d want IDLE", u32.state); end
        cyc();
        checks++; if (u32.state !== S_IDLE) begin errors++; $display("FAIL fs_stay got %0d want IDLE", u32.state); end
    endtask

    task automatic test_back_to_back();
        ex_valid = 1; ex_alu = 32'h0; ex_res = 1; ex_req = 1;
        ex_we = 1; ex_size = LD_W;
        cyc();
        dok = 1; rdata = 32'h1111_1111; ex_alu = 32'h4;
        #3;
        checks++; if ({o_valid, o_allow, o_wdata} !== {2'b11, 32'h1111_1111}) begin errors++; $display("FAIL b2b_0 got %b%b/%h want 11/11111111", o_valid, o_allow, o_wdata); end
        cyc();
        rdata = 32'h2222_2222;
        ex_res = 0; ex_req = 0; ex_alu = 32'h77;
        #3;
        checks++; if ({o_valid, o_wdata} !== {1'b1, 32'h2222_2222}) begin errors++; $display("FAIL b2b_1 got %b/%h want 1/22222222", o_valid, o_wdata); end
        cyc();
        quiet();
        #3;
        checks++; if ({u32.state == S_FULL, o_wdata} !== {1'b1, 32'h77}) begin errors++; $display("FAIL b2b_2 got %0d/%h want FULL/77", u32.state, o_wdata); end
        cyc();
    endtask

    task automatic test_ld_d64();
        v64 = 1; alu64 = 64'h8; ex_res = 1; ex_req = 1;
        ex_we = 1; ex_size = LD_D; ex_pc = 32'h200;
        cyc();
        v64 = 0;
        dok64 = 1; rdata64 = 64'h8000_0000_0000_0001;
        #3;
        checks++; if (p_wdata !== 64'h8000_0000_0000_0001) begin errors++; $display("FAIL ldd_wdata got %h want 8000000000000001", p_wdata); end
        cyc();
        dok64 = 0;
        v64 = 1; alu64 = 64'h4; ex_size = LD_W;
        cyc();
        v64 = 0;
        dok64 = 1;
        #3;
        checks++; if (p_wdata !== 64'hffff_ffff_8000_0000) begin errors++; $display("FAIL ldw64_wdata got %h want ffffffff80000000", p_wdata); end
        cyc();
        dok64 = 0;
        v64 = 1; alu64 = 64'h10; ex_size = LD_D;
        cyc();
        v64 = 0;
        #3;
        checks++; if (p_pend !== 1'b1) begin errors++; $display("FAIL rstw_pend got %b want 1", p_pend); end
        reset = 1;
        cyc();
        quiet();
        reset = 0;
        #3;
        checks++; if ({p_valid, p_allow, p_we, p_csr, p_excs, p_pend} !== 6'b010000) begin errors++; $display("FAIL rstw_flags got %b want 010000", {p_valid, p_allow, p_we, p_csr, p_excs, p_pend}); end
        checks++; if ({p_wdata, p_pc} !== 96'h0) begin errors++; $display("FAIL rstw_data got %h/%h want 0/0", p_wdata, p_pc); end
        checks++; if (u64.state !== S_IDLE) begin errors++; $display("FAIL rstw_state got %0d want IDLE", u64.state); end
        cyc();
    endtask

    initial begin
        quiet();
        reset = 1;
        cyc();
        test_reset();
        test_alu();
        test_exc();
        test_ld_b();
        test_wb_stall();
        test_flush_wait();
        test_flush_same();
        test_back_to_back();
        test_ld_d64();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
